bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (>=2).
REQ-002 SHALL have parameter DIV_W, default 8, width of bit-period divider input.
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB first.
REQ-004 SHALL have parameter IDLE_LEVEL, default 0, ser_out level when no frame is active.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port s_valid  input  1  upstream word valid.
REQ-008 SHALL have port s_ready  output  1  block can accept a word.
REQ-009 SHALL have port s_data  input  DATA_W  word to serialize.
REQ-010 SHALL have port div  input  DIV_W  bit period minus one, in clk cycles.
REQ-011 SHALL have port ser_out  output  1  registered serial bit stream to the downstream sequence detector input.
REQ-012 SHALL have port busy  output  1  high while a frame is on ser_out.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-014 SHALL transfer a word only on a rising edge where s_valid and s_ready are both high.
REQ-015 SHALL implement states IDLE and SHIFT, plus PARITY when the REQ-029 macro is defined.
REQ-016 SHALL, in IDLE, load an accepted word directly into the shift register, go to SHIFT, and drive its first bit on ser_out from the next cycle (latency 1).
REQ-017 SHALL latch div at frame start and hold each bit on ser_out for exactly latched div+1 cycles; div changes mid-frame take effect on the next frame only.
REQ-018 SHALL emit DATA_W data bits per frame in the order set by MSB_FIRST.
REQ-019 SHALL provide one holding-buffer entry; s_ready = buffer empty, so one word is accepted while busy.
REQ-020 SHALL, when the final bit period ends and the buffer is full, load the buffered word, free the buffer, and start the next frame with no idle cycle between frames.
REQ-021 SHALL accept a new word in the same cycle the buffer drains (s_ready high that cycle).
REQ-022 SHALL, when the final bit period ends and the buffer is empty, return to IDLE with ser_out = IDLE_LEVEL from the next cycle.
REQ-023 SHALL pulse frame_done for exactly one cycle, the last cycle of the frame's final bit period, including on back-to-back frames.
REQ-024 SHALL hold busy high in SHIFT and PARITY and low in IDLE.
REQ-025 SHALL keep the bit-period counter DIV_W bits wide; div = max value yields 2^DIV_W cycles per bit without overflow.

Reset
REQ-026 SHALL, on rst_n low, immediately force state = IDLE, ser_out = IDLE_LEVEL, busy = 0, frame_done = 0, buffer empty, and counters = 0.
REQ-027 SHALL drive s_ready = 1 during and after reset.
REQ-028 SHALL discard any in-flight or buffered word on reset mid-frame and emit no frame_done for it.

Configuration
REQ-029 SHALL, with macro BIT_SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of data bits) after the data bits, held div+1 cycles, with frame_done moved to that bit's last cycle.
REQ-030 SHALL, without BIT_SERIALIZER_PARITY_EN, omit the PARITY state; a frame is exactly DATA_W bit periods.

Verification
REQ-031 SHALL cover: div=0, MSB_FIRST=1, send 0xB1 from IDLE -> ser_out 1,0,1,1,0,0,0,1 in cycles 1-8 after handshake, frame_done in cycle 8, ser_out=0 in cycle 9.
REQ-032 SHALL cover: div=2, send 0x80 -> ser_out high cycles 1-3, low cycles 4-24, busy high for 24 cycles.
REQ-033 SHALL cover: div=0, back-to-back 0xFF then 0x00 -> 8 ones then 8 zeros, no gap, two frame_done pulses in cycles 8 and 16.
REQ-034 SHALL cover: three words offered continuously -> first two accepted on consecutive edges, s_ready low until cycle 8, third accepted in cycle 8.
REQ-035 SHALL cover: rst_n asserted at bit 4 of 0xAA with one word buffered -> ser_out=IDLE_LEVEL, busy=0, s_ready=1 immediately; no further bits or frame_done.
REQ-036 SHALL cover, with BIT_SERIALIZER_PARITY_EN, div=0: 0x07 -> 8 data bits then parity 1 in cycle 9, frame_done in cycle 9.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: framed parallel-to-serial shifter with one-word holding buffer.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int IDLE_LEVEL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [DIV_W-1:0]  div,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done
);
    localparam int IW = $clog2(DATA_W);
`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
    state_t state, state_n;
    logic [DATA_W-1:0] sh, sh_nx, buf_data, next_word;
    logic [DIV_W-1:0] cnt, div_q;
    logic [IW-1:0] idx;
    logic buf_full, accept, bit_end, last_data, frame_end, have_next, start;

    function automatic logic head(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    always_comb begin
        busy = state != IDLE;
        bit_end = busy && cnt == div_q;
        last_data = idx == IW'(DATA_W-1);
`ifdef BIT_SERIALIZER_PARITY_EN
        frame_end = bit_end && state == PARITY;
`else
        frame_end = bit_end && last_data;
`endif
        frame_done = frame_end;
        // the buffer frees on the last cycle of a frame, so a word can be taken that same cycle
        s_ready = !buf_full || frame_end;
        accept = s_valid && s_ready;
        have_next = buf_full || accept;
        next_word = buf_full ? buf_data : s_data;
        start = (state == IDLE && accept) || (frame_end && have_next);
        sh_nx = (MSB_FIRST != 0) ? sh << 1 : sh >> 1;
        state_n = state;
        if (start)
            state_n = SHIFT;
        else if (frame_end)
            state_n = IDLE;
`ifdef BIT_SERIALIZER_PARITY_EN
        else if (state == SHIFT && bit_end && last_data)
            state_n = PARITY;
`endif
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
            buf_data <= '0;
            buf_full <= 1'b0;
            cnt <= '0;
            div_q <= '0;
            idx <= '0;
            ser_out <= 1'(IDLE_LEVEL);
`ifdef BIT_SERIALIZER_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            buf_full <= frame_end ? (buf_full && accept) : (buf_full || (accept && busy));
            if (accept)
                buf_data <= s_data;
            if (start) begin
                sh <= next_word;
                div_q <= div;
                cnt <= '0;
                idx <= '0;
                ser_out <= head(next_word);
`ifdef BIT_SERIALIZER_PARITY_EN
                par <= ^next_word;
`endif
            end else if (bit_end) begin
                cnt <= '0;
                if (frame_end)
                    ser_out <= 1'(IDLE_LEVEL);
`ifdef BIT_SERIALIZER_PARITY_EN
                else if (last_data)
                    ser_out <= par;
`endif
                else begin
                    idx <= idx + 1'b1;
                    sh <= sh_nx;
                    ser_out <= head(sh_nx);
                end
            end else if (busy)
                cnt <= cnt + 1'b1;
        end
    end
endmodule
